cn_min_sequencer: RTL
=====================

Name: cn_min_sequencer

Overview:
Serial check-node magnitude scheduler for the min-sum LDPC decoder.
- Accepts one variable-to-check message per cycle over a valid/ready handshake.
- Over a row of DC messages it tracks min1, min2, the index of min1, and the sign parity.
- Presents the row result to the check-to-variable update stage through a registered valid/ready output.
- Sequences the compare/select function of the pipelined 2-input min stage across a full check-node degree.

Parameters:
W, 6, message width: sign bit at MSB, magnitude in bits W-2:0
DC, 8, check-node degree (messages per row); DC >= 2
IDXW, 3, index width, equal to $clog2(DC)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low
clr  input  1  synchronous abort of the current row, active-high
in_valid  input  1  in_msg is valid
in_ready  output  1  block accepts in_msg this cycle (registered)
in_msg  input  W  message: [W-1] sign, [W-2:0] magnitude
out_valid  output  1  row result valid (registered)
out_ready  input  1  downstream accepts the result
min1  output  W-1  smallest magnitude in the row
min2  output  W-1  second smallest magnitude in the row
min1_idx  output  IDXW  position 0..DC-1 of min1 within the row
sign_par  output  1  XOR of all DC sign bits
busy  output  1  high in ACC or HOLD

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, in_ready=0, out_valid=0, min1=0, min2=0, min1_idx=0, sign_par=0, busy=0.
- in_ready=1 from the first clk edge after rst is released, while in IDLE or ACC.
- Accept event: in_valid & in_ready at a rising edge.
- FSM states: IDLE, ACC, HOLD.
- IDLE, on accept:
  - min1=mag, min2=all-ones (2^(W-1)-1), min1_idx=0, sign_par=sign, cnt=1
  - next state ACC.
- ACC, on accept:
  - if mag < min1: min2=min1, min1=mag, min1_idx=cnt
  - else if mag < min2: min2=mag
  - sign_par ^= sign; cnt++.
- Comparisons are strict less-than. On a tie with min1, the earlier index is kept as min1 and the new value becomes min2.
- When the accepted element is number DC-1 (cnt==DC-1):
  - next state HOLD, out_valid=1 and in_ready=0 from the next edge
  - latency: out_valid one cycle after the last accept.
- Bubbles (in_valid=0) in IDLE or ACC: no state change.
- HOLD:
  - in_ready=0, in_valid ignored
  - min1/min2/min1_idx/sign_par held stable while out_valid=1
  - on out_valid & out_ready: out_valid=0, next state IDLE, in_ready=1 next cycle
  - no same-cycle accept of the next row; there is no combinational path from out_ready to in_ready.
- Row throughput: DC+1 cycles minimum (DC accepts plus 1 HOLD cycle, with out_ready held high).
- Result registers keep the last row values after the handshake; they are overwritten by the next row.
- clr=1 (synchronous, priority over accept and handshake):
  - state=IDLE, cnt=0, out_valid=0, in_ready=1 next cycle
  - an element presented with clr is discarded.
- rst asserted mid-row or in HOLD: immediate return to reset values; the partial row is lost.
- cnt width is IDXW. It never wraps, because the transition to HOLD occurs at cnt==DC-1.

Decomposition:
- Shared package (cn_pkg):
  - W, DC, IDXW defaults
  - MAG_MAX constant (all-ones magnitude)
  - state enum {IDLE, ACC, HOLD}
- One sub-module, cn_min_update, purely combinational:
  - inputs: min1, min2, idx, mag, cnt
  - outputs: next min1, min2, idx
  - implements the strict-less update above and is reused by the later parallel check-node unit.

Test Plan:
1. rst low mid-row, after 3 accepts -> all outputs 0 immediately; in_ready=1 one cycle after release; the next row computes from scratch.
2. Back-to-back row, magnitudes 9,4,12,4,7,31,2,5 with signs 1,0,0,1,0,0,1,0 -> min1=2, min2=4, min1_idx=6, sign_par=1; out_valid one cycle after the 8th accept.
3. All magnitudes 3, all signs 0 -> min1=3, min2=3, min1_idx=0, sign_par=0.
4. Case 2 with out_ready low for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored; after out_ready=1, IDLE, and a following row 1,1,... gives min1=1, min1_idx=0.
5. Case 2 with random in_valid bubbles (0-3 cycles between elements) -> identical result to case 2.
6. clr pulse after 3 accepts -> no out_valid; a new row 30,29,28,27,26,25,24,23 -> min1=23, min2=24, min1_idx=7.

Source files
------------

// File: rtl/cn_pkg.sv
// cn_pkg: shared constants and types for the min-sum check-node blocks.
//   W_DEF    - default message width (sign at MSB, magnitude below)
//   DC_DEF   - default check-node degree
//   IDXW_DEF - default index width, $clog2(DC_DEF)
//   MAG_MAX  - all-ones magnitude for the default width
//   state_t  - sequencer states
package cn_pkg;
    localparam int W_DEF    = 6;
    localparam int DC_DEF   = 8;
    localparam int IDXW_DEF = $clog2(DC_DEF);
    localparam logic [W_DEF-2:0] MAG_MAX = '1;
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
endpackage

// File: rtl/cn_min_update.sv
// cn_min_update: combinational strict-less update of a running (min1, min2, idx) triple.
//   min1, min2 - current smallest and second smallest magnitudes
//   idx        - current position of min1
//   mag, cnt   - new magnitude and its position in the row
//   min1_nx, min2_nx, idx_nx - updated triple
// A tie with min1 keeps the earlier index and pushes the new value into min2.
module cn_min_update
    import cn_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input  logic [W-2:0]    min1,
    input  logic [W-2:0]    min2,
    input  logic [IDXW-1:0] idx,
    input  logic [W-2:0]    mag,
    input  logic [IDXW-1:0] cnt,
    output logic [W-2:0]    min1_nx,
    output logic [W-2:0]    min2_nx,
    output logic [IDXW-1:0] idx_nx
);
    logic lt1, lt2;
    assign lt1     = mag < min1;
    assign lt2     = mag < min2;
    assign min1_nx = lt1 ? mag : min1;
    assign min2_nx = lt1 ? min1 : (lt2 ? mag : min2);
    assign idx_nx  = lt1 ? cnt : idx;
endmodule

// File: rtl/cn_min_sequencer.sv
// cn_min_sequencer: serial check-node scheduler tracking min1/min2/min1 index/sign parity per row.
//   clk, rst (async, active-low), clr (sync row abort)
//   in_valid/in_ready/in_msg    - one message per accept, [W-1] sign, [W-2:0] magnitude
//   out_valid/out_ready         - registered row-result handshake
//   min1, min2, min1_idx, sign_par - row result, held while out_valid is high
//   busy                        - high while a row is in progress or being presented
module cn_min_sequencer
    import cn_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int DC   = DC_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_msg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-2:0]    min1,
    output logic [W-2:0]    min2,
    output logic [IDXW-1:0] min1_idx,
    output logic            sign_par,
    output logic            busy
);
    localparam logic [IDXW-1:0] LAST = IDXW'(DC - 1);

    state_t          state, state_nx;
    logic [IDXW-1:0] cnt, cnt_nx, idx_nx, u_idx;
    logic [W-2:0]    m1_nx, m2_nx, u_m1, u_m2, mag;
    logic            sp_nx, sgn, accept;

    assign mag    = in_msg[W-2:0];
    assign sgn    = in_msg[W-1];
    assign accept = in_valid & in_ready;
    assign busy   = state != IDLE;

    cn_min_update #(.W(W), .IDXW(IDXW)) u_upd (
        .min1    (min1),
        .min2    (min2),
        .idx     (min1_idx),
        .mag     (mag),
        .cnt     (cnt),
        .min1_nx (u_m1),
        .min2_nx (u_m2),
        .idx_nx  (u_idx)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        m1_nx    = min1;
        m2_nx    = min2;
        idx_nx   = min1_idx;
        sp_nx    = sign_par;
        if (clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    m1_nx    = mag;
                    m2_nx    = '1;
                    idx_nx   = '0;
                    sp_nx    = sgn;
                    cnt_nx   = IDXW'(1);
                    state_nx = ACC;
                end
                ACC: if (accept) begin
                    m1_nx    = u_m1;
                    m2_nx    = u_m2;
                    idx_nx   = u_idx;
                    sp_nx    = sign_par ^ sgn;
                    // cnt returns to 0 on the last element so it never wraps
                    cnt_nx   = (cnt == LAST) ? '0 : cnt + 1'b1;
                    state_nx = (cnt == LAST) ? HOLD : ACC;
                end
                HOLD: if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // in_ready/out_valid are registered from the next state, so out_ready never reaches in_ready combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            min1      <= '0;
            min2      <= '0;
            min1_idx  <= '0;
            sign_par  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            in_ready  <= state_nx != HOLD;
            out_valid <= state_nx == HOLD;
            min1      <= m1_nx;
            min2      <= m2_nx;
            min1_idx  <= idx_nx;
            sign_par  <= sp_nx;
        end
    end
endmodule
